// File: rtl/pipe_mult_unit.sv
// pipe_mult_unit
// Fully pipelined RV32M multiply unit for the execute stage. One multiply
// (MUL, MULH, MULHSU, MULHU) can enter per cycle. The issue packet travels
// with the operands, and the result comes out NUM_STAGES cycles later.
//
// Ports:
//   clock, reset  rising-edge clock, synchronous active-high reset
//   flush         kills every in-flight op and any op offered this cycle
//   in_valid      request valid
//   in_ready      unit can accept this cycle
//   mcand         operand rs1
//   mplier        operand rs2
//   func          ALU_MUL / ALU_MULH / ALU_MULHSU / ALU_MULHU (others act as MULHU)
//   in_packet     issue packet carried to the output
//   out_valid     result valid
//   out_ready     consumer takes the result
//   product       XLEN-bit result
//   out_packet    packet belonging to the result on the output

package pipe_mult_pkg;

    typedef enum logic [4:0] {
        ALU_ADD    = 5'h00,
        ALU_SUB    = 5'h01,
        ALU_SLT    = 5'h02,
        ALU_SLTU   = 5'h03,
        ALU_AND    = 5'h04,
        ALU_OR     = 5'h05,
        ALU_XOR    = 5'h06,
        ALU_SLL    = 5'h07,
        ALU_SRL    = 5'h08,
        ALU_SRA    = 5'h09,
        ALU_MUL    = 5'h0A,
        ALU_MULH   = 5'h0B,
        ALU_MULHSU = 5'h0C,
        ALU_MULHU  = 5'h0D
    } ALU_FUNC;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [4:0]  dest_reg_idx;
        logic        valid;
    } IS_EX_PACKET;

endpackage

module pipe_mult_unit
    import pipe_mult_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int NUM_STAGES = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] mcand,
    input  logic [XLEN-1:0] mplier,
    input  ALU_FUNC         func,
    input  IS_EX_PACKET     in_packet,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] product,
    output IS_EX_PACKET     out_packet
);

    localparam int W2    = 2 * XLEN;
    localparam int CHUNK = W2 / NUM_STAGES;
    localparam int LAST  = NUM_STAGES - 1;

    logic [NUM_STAGES-1:0] valid_q;
    logic [NUM_STAGES-1:0] valid_d;
    logic [W2-1:0]         mcand_q  [NUM_STAGES];
    logic [W2-1:0]         mcand_d  [NUM_STAGES];
    logic [W2-1:0]         mplier_q [NUM_STAGES];
    logic [W2-1:0]         mplier_d [NUM_STAGES];
    logic [W2-1:0]         acc_q    [NUM_STAGES];
    logic [W2-1:0]         acc_d    [NUM_STAGES];
    ALU_FUNC               func_q   [NUM_STAGES];
    ALU_FUNC               func_d   [NUM_STAGES];
    IS_EX_PACKET           packet_q [NUM_STAGES];
    IS_EX_PACKET           packet_d [NUM_STAGES];

    logic          advance;
    logic          accept;
    logic          mcand_signed;
    logic          mplier_signed;
    logic [W2-1:0] mcand_ext;
    logic [W2-1:0] mplier_ext;

    // One stage's contribution. The multiplier slice is treated as unsigned.
    // Because both operands are already extended to 2*XLEN, the sum of all
    // slices modulo 2^(2*XLEN) is the correct signed or unsigned product.
    function automatic logic [W2-1:0] partial_product(
        input logic [W2-1:0] a,
        input logic [W2-1:0] b,
        input int            k
    );
        logic [CHUNK-1:0] slice;
        slice = b[k*CHUNK +: CHUNK];
        return (a * W2'(slice)) << (k * CHUNK);
    endfunction

    // Handshake and operand extension. The stall is global: when the output
    // is blocked, nothing moves, including bubbles. This keeps ordering
    // trivial and the control logic small.
    always_comb begin
        advance       = !valid_q[LAST] || out_ready;
        in_ready      = advance;
        accept        = in_valid && advance && !flush;
        mcand_signed  = (func == ALU_MUL) || (func == ALU_MULH) || (func == ALU_MULHSU);
        mplier_signed = (func == ALU_MUL) || (func == ALU_MULH);
        mcand_ext     = mcand_signed  ? {{XLEN{mcand[XLEN-1]}}, mcand}
                                      : {{XLEN{1'b0}}, mcand};
        mplier_ext    = mplier_signed ? {{XLEN{mplier[XLEN-1]}}, mplier}
                                      : {{XLEN{1'b0}}, mplier};
    end

    // Next contents of each stage. Stage 0 loads from the ports and starts
    // the accumulator with slice 0. Each later stage adds its own slice to
    // the accumulator handed over by the previous stage.
    always_comb begin
        valid_d     = '0;
        valid_d[0]  = accept;
        mcand_d[0]  = mcand_ext;
        mplier_d[0] = mplier_ext;
        func_d[0]   = func;
        packet_d[0] = in_packet;
        acc_d[0]    = partial_product(mcand_ext, mplier_ext, 0);
        for (int k = 1; k < NUM_STAGES; k++) begin
            valid_d[k]  = valid_q[k-1];
            mcand_d[k]  = mcand_q[k-1];
            mplier_d[k] = mplier_q[k-1];
            func_d[k]   = func_q[k-1];
            packet_d[k] = packet_q[k-1];
            acc_d[k]    = acc_q[k-1] + partial_product(mcand_q[k-1], mplier_q[k-1], k);
        end
    end

    // Stage registers. Flush clears only the valid bits, and it wins over
    // advance. The datapath registers just follow advance, because their
    // contents are ignored once the valid bit is gone.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= '0;
            for (int k = 0; k < NUM_STAGES; k++) begin
                mcand_q[k]  <= '0;
                mplier_q[k] <= '0;
                acc_q[k]    <= '0;
                func_q[k]   <= ALU_MUL;
                packet_q[k] <= '0;
            end
        end else begin
            if (flush) begin
                valid_q <= '0;
            end else if (advance) begin
                valid_q <= valid_d;
            end
            if (advance) begin
                for (int k = 0; k < NUM_STAGES; k++) begin
                    mcand_q[k]  <= mcand_d[k];
                    mplier_q[k] <= mplier_d[k];
                    acc_q[k]    <= acc_d[k];
                    func_q[k]   <= func_d[k];
                    packet_q[k] <= packet_d[k];
                end
            end
        end
    end

    // The output is taken straight from the final stage register. Only the
    // half-select depends on func, so the value stays stable while stalled.
    assign out_valid  = valid_q[LAST];
    assign out_packet = packet_q[LAST];
    assign product    = (func_q[LAST] == ALU_MUL) ? acc_q[LAST][XLEN-1:0]
                                                  : acc_q[LAST][W2-1:XLEN];

endmodule

// File: doc/pipe_mult_unit.md
# pipe_mult_unit

Parametrised, fully pipelined integer multiply functional unit for the execute stage. It accepts one RV32M multiply (MUL, MULH, MULHSU, MULHU) per cycle and carries the issuing IS_EX_PACKET alongside the operands. It returns the XLEN-bit result after a fixed latency of NUM_STAGES cycles, with valid/ready backpressure toward the completion arbiter and a flush for mispredict recovery. It replaces the single-outstanding multiply wrapper, which could not accept a new operation while one was in flight.

## Interface
Parameters:
- XLEN, default 32: operand and result width.
- NUM_STAGES, default 4: pipeline depth. Legal values are 1, 2, 4 and 8; 2*XLEN must be divisible by NUM_STAGES.

Ports (reset reset, synchronous, active-high; clock clock):
- clock  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
- flush  in  1  kill every in-flight operation, including any op presented on in_valid this cycle
- in_valid  in  1  request valid
- in_ready  out  1  unit can accept this cycle
- mcand  in  XLEN  operand rs1
- mplier  in  XLEN  operand rs2
- func  in  ALU_FUNC  ALU_MUL, ALU_MULH, ALU_MULHSU or ALU_MULHU
- in_packet  in  IS_EX_PACKET  issue packet, carried unchanged to the output
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- product  out  XLEN  result
- out_packet  out  IS_EX_PACKET  packet of the op currently on the output

## Operation
- Accept condition: in_valid && in_ready && !flush.
- Sign extension at accept:
  - mcand is sign-extended to 2*XLEN when func is MUL, MULH or MULHSU; otherwise it is zero-extended.
  - mplier is sign-extended when func is MUL or MULH; otherwise it is zero-extended.
  - Any other func value is treated as MULHU (both operands zero-extended).
- Per-stage work: with CHUNK = 2*XLEN/NUM_STAGES, stage k adds (mcand_ext × mplier_ext[k*CHUNK +: CHUNK]) << (k*CHUNK) into a 2*XLEN accumulator. Accumulation is modulo 2^(2*XLEN).
- Per-stage state: each stage register holds valid, the extended operands, the accumulator, func and the packet.
- Result select: MUL returns acc[XLEN-1:0]; the other three functions return acc[2*XLEN-1:XLEN].
- product and out_packet come from the final stage register; they are not recomputed combinationally.
- Stall rule: advance = !out_valid || out_ready, and in_ready = advance. When advance is 0, every stage holds its contents, bubbles included. This is a global stall; bubbles are not compressed.
- flush:
  - clears the valid bit of every stage on the next edge;
  - blocks acceptance of any op presented in the same cycle;
  - takes priority over advance;
  - leaves datapath registers don't-care.
- Reset: all stage valid bits are cleared, accumulators are cleared to 0 and packets are cleared to 0.

## Timing
- Output values after reset: out_valid=0, product=0, out_packet=0, in_ready=1.
- Latency: an op accepted at edge t appears with out_valid=1 after edge t+NUM_STAGES-1, i.e. it is visible in cycle t+NUM_STAGES, provided no stall occurs.
- Throughput: one op per cycle while out_ready=1.
- Handshake:
  - The result transfers when out_valid && out_ready.
  - While out_valid=1 && out_ready=0, product and out_packet hold stable, and in_ready=0.
- Simultaneous output transfer and input accept in the same cycle is legal and required.
- Pipeline full with output stalled: all stages hold and no op is lost. When out_ready rises, results drain in issue order.
- flush during a stall empties the pipeline. out_valid=0 on the next cycle and in_ready=1.
- Reset while ops are in flight: no output appears for those ops after reset, and the unit behaves as freshly reset.
- Ordering: results always leave in acceptance order.

## Test plan
- MUL signed, NUM_STAGES=4: mcand=0xFFFFFFFD (-3), mplier=7 -> product=0xFFFFFFEB, out_valid exactly 4 cycles after accept; out_packet equals the packet sent.
- High-half variants on 0x80000000 × 0xFFFFFFFF:
  - MULH -> 0x00000000
  - MULHSU -> 0x80000000
  - MULHU -> 0x7FFFFFFF
- Back-to-back stream: 8 ops on consecutive cycles with out_ready=1 -> 8 consecutive out_valid cycles, results in order and matching a reference model.
- Backpressure: fill the pipe, then hold out_ready=0 for 5 cycles:
  - in_ready=0 and the output stays stable throughout;
  - after release, all ops drain in order with no duplicates or drops.
- Flush: with 3 ops in flight, assert flush together with a new in_valid -> no out_valid on any later cycle for those 4 ops; an op issued the next cycle completes normally.
- Parameter sweep: repeat the random test (1000 ops, random out_ready) for NUM_STAGES = 1, 2 and 8 -> zero mismatches against a full-width reference product, with latency equal to NUM_STAGES.
